pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the fetch-stage PC register and sequences next-PC selection each cycle.
//  Arbitrates between sequential advance, pipeline stall, EX-stage redirects
//  (branch/jump/jr targets from the npc datapath) and halt (syscall).
//  Drives the IF/ID flush and keeps saturating performance counters.
//  Sits between the npc datapath and the instruction-memory address port.
// PARAMETERS
//  PC_W      12  PC width in bits (byte address; PC advances by 4)
//  RESET_PC  0   PC value loaded on reset
//  CNT_W     32  width of each performance counter
// PORTS
//  clk            in   1      system clock; all state changes on rising edge
//  rst_n          in   1      synchronous active-low reset
//  stall          in   1      load-use hazard: hold PC this cycle
//  redirect_valid in   1      EX stage resolved a taken branch/jump
//  redirect_pc    in   PC_W   redirect target from npc datapath
//  redirect_cond  in   1      1 = conditional branch, 0 = unconditional jump/jr
//  halt_req       in   1      halt instruction decoded; stop fetching
//  go             in   1      resume fetch from HALT
//  pc             out  PC_W   current fetch address (registered)
//  pc_4           out  PC_W   pc + 4, modulo 2^PC_W (combinational from pc)
//  fetch_valid    out  1      1 when fetching (state RUN)
//  flush          out  1      squash IF/ID and ID/EX this cycle (combinational)
//  halted         out  1      1 when state HALT
//  misalign       out  1      sticky: a redirect target had nonzero bits [1:0]
//  cycle_cnt      out  CNT_W  count of cycles spent in RUN
//  branch_cnt     out  CNT_W  count of accepted conditional redirects
//  jump_cnt       out  CNT_W  count of accepted unconditional redirects
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=RUN, misalign=0, all counters 0.
//   Reset wins over every other input, including mid-halt or mid-redirect.
//  States:
//   RUN:  fetch_valid=1, halted=0.
//   HALT: fetch_valid=0, halted=1, flush=0, pc frozen.
//  RUN actions, in priority order each cycle:
//   1. redirect_valid: pc <= {redirect_pc[PC_W-1:2],2'b00}; flush=1 this cycle.
//      Overrides stall and halt_req; a same-cycle halt_req is on the wrong path
//      and is dropped. Increment branch_cnt if redirect_cond=1, else jump_cnt.
//      Set misalign if redirect_pc[1:0]!=0.
//   2. halt_req: pc held; state <= HALT.
//   3. stall: pc held.
//   4. Otherwise pc <= pc_4. From pc=2^PC_W-4 this wraps to 0, with no flag.
//  HALT actions:
//   - redirect_valid, stall and halt_req are ignored; counters do not change.
//   - go=1 -> state <= RUN. Fetch resumes at the held pc; pc does not advance
//     on that edge.
//  flush = redirect_valid & (state==RUN). No registered latency.
//  cycle_cnt increments on every RUN cycle, including stall and redirect cycles.
//  All counters saturate at 2^CNT_W-1 and do not wrap.
//  pc, halted and fetch_valid are registered; the redirect PC is visible on the
//  cycle after redirect_valid.
// TESTING
//  1. Reset, idle 4 cycles -> pc 0x000,0x004,0x008,0x00C; cycle_cnt=4; flush=0.
//  2. At pc=0x010, stall=1 for 3 cycles -> pc stays 0x010; cycle_cnt +3;
//     releasing stall gives pc 0x014.
//  3. redirect_valid=1, redirect_pc=0x02C, cond=0, stall=1 and halt_req=1 in
//     the same cycle -> flush=1 that cycle; next pc=0x02C; jump_cnt=1;
//     state stays RUN.
//  4. halt_req at pc=0x030 -> next cycle halted=1, fetch_valid=0.
//     redirect_valid during HALT -> no pc change, flush=0.
//     After 5 cycles, go=1 -> RUN with pc=0x030; cycle_cnt frozen during HALT.
//  5. pc=0xFFC, no events -> pc=0x000. Separately, redirect_pc=0x02E with
//     cond=1 -> pc=0x02C, misalign=1 (still 1 after 10 cycles), branch_cnt=1.
//  6. rst_n=0 while in HALT with counters nonzero -> next cycle pc=0x000,
//     fetch_valid=1, halted=0, misalign=0, all counters 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-stage sequencing bus: EX/decode events in, PC and status out.
interface pc_sequencer_if #(
    parameter int PC_W  = 12,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             redirect_cond;
    logic             halt_req;
    logic             go;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_4;
    logic             fetch_valid;
    logic             flush;
    logic             halted;
    logic             misalign;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] jump_cnt;

    modport master (
        output stall, redirect_valid, redirect_pc, redirect_cond, halt_req, go,
        input  pc, pc_4, fetch_valid, flush, halted, misalign,
               cycle_cnt, branch_cnt, jump_cnt
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, redirect_cond, halt_req, go,
        output pc, pc_4, fetch_valid, flush, halted, misalign,
               cycle_cnt, branch_cnt, jump_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register with redirect/halt/stall arbitration, IF/ID flush and
// saturating performance counters.
module pc_sequencer #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_4;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] branch_q, branch_d;
    logic [CNT_W-1:0] jump_q, jump_d;
    logic             flush_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pc_4 = pc_q + PC_W'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        cycle_d    = cycle_q;
        branch_d   = branch_q;
        jump_d     = jump_q;
        flush_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                cycle_d = sat_inc(cycle_q);
                // A redirect means anything decoded this cycle is wrong-path,
                // so it beats both halt_req and stall.
                if (bus.redirect_valid) begin
                    flush_c = 1'b1;
                    pc_d    = {bus.redirect_pc[PC_W-1:2], 2'b00};
                    if (bus.redirect_cond) begin
                        branch_d = sat_inc(branch_q);
                    end else begin
                        jump_d = sat_inc(jump_q);
                    end
                    if (|bus.redirect_pc[1:0]) begin
                        misalign_d = 1'b1;
                    end
                end else if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (!bus.stall) begin
                    pc_d = pc_4;
                end
            end
            ST_HALT: begin
                if (bus.go) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            cycle_q    <= '0;
            branch_q   <= '0;
            jump_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            cycle_q    <= cycle_d;
            branch_q   <= branch_d;
            jump_q     <= jump_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_4        = pc_4;
    assign bus.fetch_valid = (state_q == ST_RUN);
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.flush       = flush_c;
    assign bus.misalign    = misalign_q;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.branch_cnt  = branch_q;
    assign bus.jump_cnt    = jump_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios followed by random traffic, all checked each cycle
// against a behavioural model of the fetch sequencer.
module tb_pc_sequencer;
    localparam int PC_W  = 12;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int PMASK = (1 << PC_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_step   = 0;

    // model state
    int m_pc, m_cyc, m_br, m_jp;
    bit m_halt, m_mis;

    pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d obs=0x%0h exp=0x%0h", tag, n_step, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_cyc = 0; m_br = 0; m_jp = 0; m_halt = 0; m_mis = 0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance model at edge.
    task automatic step(input bit s, input bit rv, input int rp, input bit rc,
                        input bit h, input bit g, input bit rn);
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = PC_W'(rp);
        bus.redirect_cond  = rc;
        bus.halt_req       = h;
        bus.go             = g;
        rst_n              = rn;
        @(negedge clk);
        check("pc",          32'(bus.pc),          32'(m_pc));
        check("pc_4",        32'(bus.pc_4),        32'((m_pc + 4) & PMASK));
        check("fetch_valid", 32'(bus.fetch_valid), 32'(!m_halt));
        check("halted",      32'(bus.halted),      32'(m_halt));
        check("flush",       32'(bus.flush),       32'(rv && !m_halt));
        check("misalign",    32'(bus.misalign),    32'(m_mis));
        check("cycle_cnt",   32'(bus.cycle_cnt),   32'(m_cyc));
        check("branch_cnt",  32'(bus.branch_cnt),  32'(m_br));
        check("jump_cnt",    32'(bus.jump_cnt),    32'(m_jp));
        $display("step=%0d rn=%0b s=%0b rv=%0b rp=%03h rc=%0b h=%0b g=%0b pc=%03h halted=%0b",
                 n_step, rn, s, rv, rp, rc, h, g, bus.pc, bus.halted);
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else if (!m_halt) begin
            m_cyc = sat(m_cyc);
            if (rv) begin
                m_pc = rp & PMASK & ~3;
                if (rc) m_br = sat(m_br); else m_jp = sat(m_jp);
                if ((rp & 3) != 0) m_mis = 1;
            end else if (h) begin
                m_halt = 1;
            end else if (!s) begin
                m_pc = (m_pc + 4) & PMASK;
            end
        end else if (g) begin
            m_halt = 0;
        end
        #1;
        n_step++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    int cyc_before;

    initial begin
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
        bus.redirect_cond = 0; bus.halt_req = 0; bus.go = 0;
        rst_n = 0;
        @(posedge clk); #1;
        model_reset();
        check("rst_pc",    32'(bus.pc), 32'h000);
        check("rst_cycle", 32'(bus.cycle_cnt), 32'd0);

        // idle advance
        idle(4);
        check("t1_pc", 32'(bus.pc), 32'h010);
        check("t1_cyc", 32'(bus.cycle_cnt), 32'd4);
        // stall holds
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1);
        check("t2_pc", 32'(bus.pc), 32'h010);
        check("t2_cyc", 32'(bus.cycle_cnt), 32'd7);
        idle(1);
        check("t2_rel", 32'(bus.pc), 32'h014);
        // redirect beats stall and halt
        step(1, 1, 'h02C, 0, 1, 0, 1);
        check("t3_pc", 32'(bus.pc), 32'h02C);
        check("t3_jump", 32'(bus.jump_cnt), 32'd1);
        check("t3_run", 32'(bus.halted), 32'd0);
        idle(1);
        // halt and resume
        step(0, 0, 0, 0, 1, 0, 1);
        check("t4_halted", 32'(bus.halted), 32'd1);
        check("t4_fv", 32'(bus.fetch_valid), 32'd0);
        cyc_before = int'(bus.cycle_cnt);
        step(0, 1, 'h100, 1, 0, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 0, 1, 1);
        check("t4_pc", 32'(bus.pc), 32'h030);
        check("t4_run", 32'(bus.halted), 32'd0);
        check("t4_cyc", 32'(bus.cycle_cnt), 32'(cyc_before));
        // wrap and misaligned branch
        step(0, 1, 'hFFC, 0, 0, 0, 1);
        idle(1);
        check("t5_wrap", 32'(bus.pc), 32'h000);
        step(0, 1, 'h02E, 1, 0, 0, 1);
        check("t5_pc", 32'(bus.pc), 32'h02C);
        check("t5_br", 32'(bus.branch_cnt), 32'd1);
        idle(10);
        check("t5_mis", 32'(bus.misalign), 32'd1);
        // reset from halt
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t6_pc", 32'(bus.pc), 32'h000);
        check("t6_fv", 32'(bus.fetch_valid), 32'd1);
        check("t6_mis", 32'(bus.misalign), 32'd0);
        check("t6_cyc", 32'(bus.cycle_cnt), 32'd0);
        check("t6_jump", 32'(bus.jump_cnt), 32'd0);

        // random traffic; long enough to saturate the narrow counters
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(3) == 0),
                 ($urandom_range(5) == 0),
                 int'($urandom_range(PMASK)),
                 ($urandom_range(1) == 1),
                 ($urandom_range(15) == 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(999) != 0));
        end
        check("sat_cyc", 32'(bus.cycle_cnt), 32'(m_cyc));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
